dm_core: RTL and testbench



---
 rtl/dm_pkg.sv | 51 +++++
 rtl/dmi_if.sv | 16 +
 rtl/dm_abstract_fsm.sv | 103 ++++++++++
 rtl/dm_core.sv | 134 +++++++++++++
 tb/tb_dm_core.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/dm_pkg.sv
// Shared Debug Module definitions: DMI register addresses, cmderr codes and
// packed views of the dmcontrol, abstractcs and command registers.
package dm_pkg;

  localparam logic [6:0] DM_DATA0      = 7'h04;
  localparam logic [6:0] DM_DMCONTROL  = 7'h10;
  localparam logic [6:0] DM_DMSTATUS   = 7'h11;
  localparam logic [6:0] DM_ABSTRACTCS = 7'h16;
  localparam logic [6:0] DM_COMMAND    = 7'h17;

  localparam logic [15:0] GPR_BASE = 16'h1000;

  typedef enum logic [2:0] {
    CMDERR_NONE       = 3'd0,
    CMDERR_BUSY       = 3'd1,
    CMDERR_NOTSUP     = 3'd2,
    CMDERR_EXCEPTION  = 3'd3,
    CMDERR_HALTRESUME = 3'd4
  } cmderr_e;

  typedef struct packed {
    logic        haltreq;
    logic        resumereq;
    logic [27:0] rsvd;
    logic        ndmreset;
    logic        dmactive;
  } dmcontrol_t;

  typedef struct packed {
    logic [2:0]  rsvd0;
    logic [4:0]  progbufsize;
    logic [10:0] rsvd1;
    logic        busy;
    logic        rsvd2;
    cmderr_e     cmderr;
    logic [3:0]  rsvd3;
    logic [3:0]  datacount;
  } abstractcs_t;

  typedef struct packed {
    logic [7:0]  cmdtype;
    logic        rsvd;
    logic [2:0]  aarsize;
    logic        aarpostincrement;
    logic        postexec;
    logic        transfer;
    logic        write;
    logic [15:0] regno;
  } command_t;

endpackage

// File: rtl/dmi_if.sv
// DMI bus between the JTAG DTM (master) and the Debug Module (slave).
// The shared data bus carries write data from the master and read data from the slave.
interface dmi_if;
  logic        read;
  logic        write;
  logic [6:0]  address;
  logic [31:0] wdata;
  logic [31:0] rdata;
  wire  [31:0] data;

  // Slave owns the bus only during reads; master only during writes.
  assign data = read ? rdata : (write ? wdata : 'z);

  modport master (output read, output write, output address, output wdata, input data);
  modport slave  (input read, input write, input address, input data, output rdata);
endinterface

// File: rtl/dm_abstract_fsm.sv
// Abstract "access register" engine: validates commands, runs the GPR
// request/ack handshake and owns data0 and cmderr.
module dm_abstract_fsm
  import dm_pkg::*;
#(
  parameter int NUM_GPR = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_dmactive,
  input  logic        i_cmd_we,
  input  logic        i_data0_we,
  input  logic        i_abscs_we,
  input  logic [31:0] i_wdata,
  input  logic        i_hart_halted,
  input  logic [31:0] i_reg_rdata,
  input  logic        i_reg_ack,
  output logic        o_busy,
  output cmderr_e     o_cmderr,
  output logic [31:0] o_data0,
  output logic        o_reg_req,
  output logic        o_reg_we,
  output logic [4:0]  o_reg_addr,
  output logic [31:0] o_reg_wdata
);

  typedef enum logic {S_IDLE, S_REQ} state_e;

  state_e      r_state;
  cmderr_e     r_cmderr;
  logic [31:0] r_data0;
  logic        r_reg_req;
  logic        r_reg_we;
  logic [4:0]  r_reg_addr;
  logic [31:0] r_reg_wdata;

  command_t w_cmd;
  logic     w_regno_ok;
  logic     w_cmd_bad;
  logic     w_unused_cmd;

  assign w_cmd        = command_t'(i_wdata);
  assign w_unused_cmd = ^{w_cmd.rsvd, w_cmd.aarpostincrement, w_cmd.postexec};
  assign w_regno_ok   = ({1'b0, w_cmd.regno} >= {1'b0, GPR_BASE}) &&
                        ({1'b0, w_cmd.regno} <  ({1'b0, GPR_BASE} + 17'(NUM_GPR)));
  assign w_cmd_bad    = (w_cmd.cmdtype != 8'd0) || (w_cmd.aarsize != 3'd2) ||
                        (w_cmd.transfer && !w_regno_ok);

  always_ff @(posedge clk) begin
    if (rst || !i_dmactive) begin
      r_state     <= S_IDLE;
      r_cmderr    <= CMDERR_NONE;
      r_data0     <= '0;
      r_reg_req   <= 1'b0;
      r_reg_we    <= 1'b0;
      r_reg_addr  <= '0;
      r_reg_wdata <= '0;
    end else begin
      if (i_abscs_we)
        r_cmderr <= cmderr_e'(r_cmderr & ~i_wdata[10:8]);
      case (r_state)
        S_IDLE: begin
          if (i_data0_we)
            r_data0 <= i_wdata;
          if (i_cmd_we && (r_cmderr == CMDERR_NONE)) begin
            if (w_cmd_bad)
              r_cmderr <= CMDERR_NOTSUP;
            else if (!i_hart_halted)
              r_cmderr <= CMDERR_HALTRESUME;
            else if (w_cmd.transfer) begin
              r_state     <= S_REQ;
              r_reg_req   <= 1'b1;
              r_reg_we    <= w_cmd.write;
              r_reg_addr  <= w_cmd.regno[4:0];
              r_reg_wdata <= r_data0;
            end
          end
        end
        S_REQ: begin
          if (i_cmd_we || i_data0_we)
            r_cmderr <= CMDERR_BUSY;
          // The ack result overrides any data0 write landing in the same cycle.
          if (i_reg_ack) begin
            r_state   <= S_IDLE;
            r_reg_req <= 1'b0;
            if (!r_reg_we)
              r_data0 <= i_reg_rdata;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy      = (r_state != S_IDLE);
  assign o_cmderr    = r_cmderr;
  assign o_data0     = r_data0;
  assign o_reg_req   = r_reg_req;
  assign o_reg_we    = r_reg_we;
  assign o_reg_addr  = r_reg_addr;
  assign o_reg_wdata = r_reg_wdata;

endmodule

// File: rtl/dm_core.sv
// Debug Module DMI target: register decode, halt/resume control for one hart,
// and abstract GPR access through dm_abstract_fsm.
module dm_core
  import dm_pkg::*;
#(
  parameter int         NUM_GPR    = 32,
  parameter logic [3:0] DM_VERSION = 4'd2
) (
  input  logic        clk,
  input  logic        rst,
  dmi_if.slave        dmi,
  output logic        ndmreset,
  output logic        hart_halt_req,
  output logic        hart_resume_req,
  input  logic        hart_halted,
  output logic        hart_reg_req,
  output logic        hart_reg_we,
  output logic [4:0]  hart_reg_addr,
  output logic [31:0] hart_reg_wdata,
  input  logic [31:0] hart_reg_rdata,
  input  logic        hart_reg_ack
);

  logic r_dmactive;
  logic r_haltreq;
  logic r_resumereq;
  logic r_ndmreset;
  logic r_resume_pending;
  logic r_resumeack;

  logic        w_wr_dmcontrol;
  logic        w_wr_command;
  logic        w_wr_data0;
  logic        w_wr_abscs;
  logic        w_dmactive_nxt;
  logic        w_resume_wr;
  logic        w_busy;
  cmderr_e     w_cmderr;
  logic [31:0] w_data0;
  logic [31:0] w_rdata;
  dmcontrol_t  w_dmc;
  abstractcs_t w_abscs;
  logic        w_unused_dmc;

  assign w_wr_dmcontrol = dmi.write && (dmi.address == DM_DMCONTROL);
  assign w_wr_command   = dmi.write && (dmi.address == DM_COMMAND);
  assign w_wr_data0     = dmi.write && (dmi.address == DM_DATA0);
  assign w_wr_abscs     = dmi.write && (dmi.address == DM_ABSTRACTCS);
  assign w_dmc          = dmcontrol_t'(dmi.data);
  assign w_unused_dmc   = ^w_dmc.rsvd;

  // Looking at the incoming dmactive lets a clearing write abort a command at the same edge.
  assign w_dmactive_nxt = w_wr_dmcontrol ? w_dmc.dmactive : r_dmactive;
  assign w_resume_wr    = w_wr_dmcontrol && r_dmactive && w_dmc.resumereq && !w_dmc.haltreq;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dmactive       <= 1'b0;
      r_haltreq        <= 1'b0;
      r_resumereq      <= 1'b0;
      r_ndmreset       <= 1'b0;
      r_resume_pending <= 1'b0;
      r_resumeack      <= 1'b0;
    end else begin
      r_dmactive <= w_dmactive_nxt;
      if (!w_dmactive_nxt) begin
        r_haltreq        <= 1'b0;
        r_resumereq      <= 1'b0;
        r_ndmreset       <= 1'b0;
        r_resume_pending <= 1'b0;
        r_resumeack      <= 1'b0;
      end else begin
        if (w_wr_dmcontrol && r_dmactive) begin
          r_haltreq   <= w_dmc.haltreq;
          r_resumereq <= w_dmc.resumereq && !w_dmc.haltreq;
          r_ndmreset  <= w_dmc.ndmreset;
        end
        if (w_resume_wr) begin
          r_resume_pending <= 1'b1;
          r_resumeack      <= 1'b0;
        end else if (r_resume_pending && !hart_halted) begin
          r_resume_pending <= 1'b0;
          r_resumeack      <= 1'b1;
        end
      end
    end
  end

  dm_abstract_fsm #(.NUM_GPR(NUM_GPR)) u_abstract (
    .clk          (clk),
    .rst          (rst),
    .i_dmactive   (w_dmactive_nxt),
    .i_cmd_we     (w_wr_command),
    .i_data0_we   (w_wr_data0),
    .i_abscs_we   (w_wr_abscs),
    .i_wdata      (dmi.data),
    .i_hart_halted(hart_halted),
    .i_reg_rdata  (hart_reg_rdata),
    .i_reg_ack    (hart_reg_ack),
    .o_busy       (w_busy),
    .o_cmderr     (w_cmderr),
    .o_data0      (w_data0),
    .o_reg_req    (hart_reg_req),
    .o_reg_we     (hart_reg_we),
    .o_reg_addr   (hart_reg_addr),
    .o_reg_wdata  (hart_reg_wdata)
  );

  always_comb begin
    w_abscs             = '0;
    w_abscs.busy        = w_busy;
    w_abscs.cmderr      = w_cmderr;
    w_abscs.datacount   = 4'd1;
  end

  always_comb begin
    w_rdata = '0;
    case (dmi.address)
      DM_DATA0:      w_rdata = w_data0;
      DM_DMCONTROL:  w_rdata = {r_haltreq, r_resumereq, 28'd0, r_ndmreset, r_dmactive};
      DM_DMSTATUS:   w_rdata = {14'd0, r_resumeack, r_resumeack, 4'd0,
                                !hart_halted, !hart_halted, hart_halted, hart_halted,
                                1'b1, 3'd0, DM_VERSION};
      DM_ABSTRACTCS: w_rdata = w_abscs;
      default:       w_rdata = '0;
    endcase
  end

  assign dmi.rdata       = w_rdata;
  assign ndmreset        = r_ndmreset;
  assign hart_halt_req   = r_haltreq;
  assign hart_resume_req = r_resume_pending;

endmodule

// File: tb/tb_dm_core.sv
// Directed bench for dm_core: register reads, halt/resume handshake,
// abstract GPR commands, cmderr handling and dmactive abort.
module tb_dm_core;
  import dm_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        hart_halted;
  logic [31:0] hart_reg_rdata;
  logic        hart_reg_ack;
  logic        ndmreset, hart_halt_req, hart_resume_req;
  logic        hart_reg_req, hart_reg_we;
  logic [4:0]  hart_reg_addr;
  logic [31:0] hart_reg_wdata;

  int checks   = 0;
  int failures = 0;

  dmi_if dmi ();

  dm_core #(.NUM_GPR(32), .DM_VERSION(4'd2)) dut (
    .clk            (clk),
    .rst            (rst),
    .dmi            (dmi),
    .ndmreset       (ndmreset),
    .hart_halt_req  (hart_halt_req),
    .hart_resume_req(hart_resume_req),
    .hart_halted    (hart_halted),
    .hart_reg_req   (hart_reg_req),
    .hart_reg_we    (hart_reg_we),
    .hart_reg_addr  (hart_reg_addr),
    .hart_reg_wdata (hart_reg_wdata),
    .hart_reg_rdata (hart_reg_rdata),
    .hart_reg_ack   (hart_reg_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic dmi_wr(input logic [6:0] a, input logic [31:0] v);
    @(negedge clk);
    dmi.write = 1'b1; dmi.address = a; dmi.wdata = v;
    @(negedge clk);
    dmi.write = 1'b0; dmi.wdata = '0;
  endtask

  task automatic check_rd(input string tag, input logic [6:0] a, input logic [31:0] exp);
    logic [31:0] v;
    dmi.read = 1'b1; dmi.address = a;
    #1;
    v = dmi.data;
    dmi.read = 1'b0;
    check(tag, v, exp);
  endtask

  task automatic ack_cycle;
    @(negedge clk);
    hart_reg_ack = 1'b1;
    @(negedge clk);
    hart_reg_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; hart_halted = 1'b0; hart_reg_rdata = '0; hart_reg_ack = 1'b0;
    dmi.read = 1'b0; dmi.write = 1'b0; dmi.address = '0; dmi.wdata = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_outputs", {25'd0, ndmreset, hart_halt_req, hart_resume_req, hart_reg_req,
                          hart_reg_we, hart_reg_addr != 5'd0, hart_reg_wdata != 32'd0}, 32'd0);
    check_rd("rst_dmstatus",   DM_DMSTATUS,   32'h0000_0C82);
    check_rd("rst_abstractcs", DM_ABSTRACTCS, 32'h0000_0001);
    check_rd("rst_dmcontrol",  DM_DMCONTROL,  32'h0000_0000);
    check_rd("unmapped_read",  7'h7F,         32'h0000_0000);

    // While dmactive=0 only dmactive is taken
    dmi_wr(DM_DMCONTROL, 32'h8000_0003);
    check_rd("inactive_dmc", DM_DMCONTROL, 32'h0000_0001);
    check("inactive_haltreq", {31'd0, hart_halt_req}, 32'd0);
    dmi_wr(DM_DMCONTROL, 32'h8000_0003);
    check("haltreq_out", {30'd0, hart_halt_req, ndmreset}, 32'd3);
    check_rd("active_dmc", DM_DMCONTROL, 32'h8000_0003);
    hart_halted = 1'b1;
    check_rd("halted_dmstatus", DM_DMSTATUS, 32'h0000_0382);
    dmi_wr(DM_DMSTATUS, 32'hFFFF_FFFF);
    check_rd("ro_dmstatus", DM_DMSTATUS, 32'h0000_0382);

    // Abstract GPR write
    dmi_wr(DM_DATA0, 32'hDEAD_BEEF);
    check_rd("data0_rw", DM_DATA0, 32'hDEAD_BEEF);
    dmi_wr(DM_COMMAND, 32'h0023_1005);
    check("wr_req", {26'd0, hart_reg_req, hart_reg_we, hart_reg_addr}, {26'd0, 1'b1, 1'b1, 5'd5});
    check("wr_wdata", hart_reg_wdata, 32'hDEAD_BEEF);
    check_rd("wr_busy", DM_ABSTRACTCS, 32'h0000_1001);
    @(negedge clk);
    @(negedge clk);
    hart_reg_ack = 1'b1;
    check_rd("wr_busy_at_ack", DM_ABSTRACTCS, 32'h0000_1001);
    @(negedge clk);
    hart_reg_ack = 1'b0;
    check_rd("wr_done", DM_ABSTRACTCS, 32'h0000_0001);
    check("wr_req_drop", {31'd0, hart_reg_req}, 32'd0);

    // Abstract GPR read, busy data0 write, ack colliding with data0 write
    hart_reg_rdata = 32'h1234_5678;
    dmi_wr(DM_COMMAND, 32'h0022_1001);
    check("rd_req", {26'd0, hart_reg_req, hart_reg_we, hart_reg_addr}, {26'd0, 1'b1, 1'b0, 5'd1});
    dmi_wr(DM_DATA0, 32'hCAFE_F00D);
    check_rd("busy_data0_err", DM_ABSTRACTCS, 32'h0000_1101);
    @(negedge clk);
    hart_reg_ack = 1'b1;
    dmi.write = 1'b1; dmi.address = DM_DATA0; dmi.wdata = 32'h0BAD_BEEF;
    @(negedge clk);
    hart_reg_ack = 1'b0; dmi.write = 1'b0;
    check_rd("rd_data0", DM_DATA0, 32'h1234_5678);
    check_rd("rd_done_err", DM_ABSTRACTCS, 32'h0000_0101);
    dmi_wr(DM_ABSTRACTCS, 32'h0000_0700);
    check_rd("w1c_busy_err", DM_ABSTRACTCS, 32'h0000_0001);

    // Error paths
    hart_halted = 1'b0;
    dmi_wr(DM_COMMAND, 32'h0022_1001);
    check("not_halted_noreq", {31'd0, hart_reg_req}, 32'd0);
    check_rd("not_halted_err", DM_ABSTRACTCS, 32'h0000_0401);
    dmi_wr(DM_ABSTRACTCS, 32'h0000_0700);
    check_rd("w1c_clear", DM_ABSTRACTCS, 32'h0000_0001);
    dmi_wr(DM_COMMAND, 32'h0100_0000);
    check_rd("cmdtype_err", DM_ABSTRACTCS, 32'h0000_0201);
    dmi_wr(DM_COMMAND, 32'h0022_1001);
    check_rd("cmd_blocked_by_err", DM_ABSTRACTCS, 32'h0000_0201);
    dmi_wr(DM_ABSTRACTCS, 32'h0000_0700);
    hart_halted = 1'b1;
    dmi_wr(DM_COMMAND, 32'h0022_1020);
    check_rd("regno_range_err", DM_ABSTRACTCS, 32'h0000_0201);
    dmi_wr(DM_ABSTRACTCS, 32'h0000_0700);
    dmi_wr(DM_COMMAND, 32'h0032_1001);
    check_rd("aarsize_err", DM_ABSTRACTCS, 32'h0000_0201);
    dmi_wr(DM_ABSTRACTCS, 32'h0000_0200);
    dmi_wr(DM_COMMAND, 32'h0020_0000);
    check_rd("no_transfer_ok", DM_ABSTRACTCS, 32'h0000_0001);
    dmi_wr(DM_COMMAND, 32'h0023_101F);
    check("last_gpr_req", {26'd0, hart_reg_req, hart_reg_we, hart_reg_addr}, {26'd0, 1'b1, 1'b1, 5'd31});
    ack_cycle();
    check_rd("last_gpr_done", DM_ABSTRACTCS, 32'h0000_0001);

    // Resume handshake
    dmi_wr(DM_DMCONTROL, 32'h4000_0001);
    check("resume_req", {30'd0, hart_resume_req, hart_halt_req}, 32'd2);
    check_rd("resume_pending_status", DM_DMSTATUS, 32'h0000_0382);
    @(negedge clk);
    check("resume_req_held", {31'd0, hart_resume_req}, 32'd1);
    hart_halted = 1'b0;
    @(negedge clk);
    check("resume_req_drop", {31'd0, hart_resume_req}, 32'd0);
    check_rd("resumeack", DM_DMSTATUS, 32'h0003_0C82);
    dmi_wr(DM_DMCONTROL, 32'hC000_0001);
    check("halt_and_resume", {30'd0, hart_resume_req, hart_halt_req}, 32'd1);
    check_rd("resumeack_sticky", DM_DMSTATUS, 32'h0003_0C82);

    // Clearing dmactive aborts a busy command and holds state at reset
    hart_halted = 1'b1;
    dmi_wr(DM_DMCONTROL, 32'h0000_0001);
    dmi_wr(DM_DATA0, 32'hA5A5_A5A5);
    dmi_wr(DM_COMMAND, 32'h0022_1002);
    check("abort_req_before", {31'd0, hart_reg_req}, 32'd1);
    dmi_wr(DM_DMCONTROL, 32'h0000_0000);
    check("abort_req_drop", {31'd0, hart_reg_req}, 32'd0);
    check_rd("abort_not_busy", DM_ABSTRACTCS, 32'h0000_0001);
    check_rd("abort_data0", DM_DATA0, 32'h0000_0000);
    dmi_wr(DM_DATA0, 32'h5555_5555);
    check_rd("inactive_data0", DM_DATA0, 32'h0000_0000);
    check_rd("inactive_resumeack", DM_DMSTATUS, 32'h0000_0382);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
